kex_reader: RTL and testbench

- Read sequencer for the on-chip expansion-kernel store (KEX RAM: synchronous, 1-cycle read latency, no read enable).
- On a start command it walks a contiguous window of entries, absorbs the RAM read latency, and presents each entry to the downstream PE array as a valid/ready stream, honouring backpressure at full throughput.
- Each entry is split into a weight value and a lane index.

---
 rtl/kex_reader_pkg.sv | 21 ++
 rtl/kex_skid_fifo.sv | 59 +++++
 rtl/kex_reader.sv | 139 +++++++++++++
 tb/tb_kex_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kex_reader_pkg.sv
// Shared sizing and FSM state type for the KEX RAM read sequencer.
// Optional stall counter in kex_reader is enabled by defining KEX_READER_PERF_EN.
package kex_reader_pkg;

    localparam int WG_W       = 8;
    localparam int NPAR       = 8;
    localparam int KEX_N_ELEM = 512;

    localparam int KEX_IW = $clog2(NPAR);
    localparam int KEX_AW = $clog2(KEX_N_ELEM);
    localparam int KEX_DW = WG_W + KEX_IW;
    localparam int KEX_CW = KEX_AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } kex_state_t;

endpackage

// File: rtl/kex_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency between issue and the output stream.
// Push while full is only accepted when a pop frees a slot in the same cycle.
module kex_skid_fifo
    import kex_reader_pkg::*;
#(
    parameter int W = KEX_DW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = rd_ptr ? mem1 : mem0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) begin
                    mem1 <= din;
                end else begin
                    mem0 <= din;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kex_reader.sv
// Walks a contiguous KEX RAM window and streams each entry out as weight + lane index.
// Define KEX_READER_PERF_EN to add the 32-bit saturating stall_cnt output.
module kex_reader
    import kex_reader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [KEX_AW-1:0] base_addr,
    input  logic [KEX_CW-1:0] n_elem,
    output logic              busy,
    output logic              done,
    output logic [KEX_AW-1:0] ram_addr,
    input  logic [KEX_DW-1:0] ram_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WG_W-1:0]   out_wg,
    output logic [KEX_IW-1:0] out_idx,
    output logic              out_last
`ifdef KEX_READER_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    kex_state_t        state;
    kex_state_t        next_state;
    logic [KEX_AW-1:0] base_q;
    logic [KEX_CW-1:0] n_q;
    logic [KEX_CW-1:0] issue_cnt;
    logic [KEX_CW-1:0] pop_cnt;
    logic              inflight;
    logic              accept;
    logic              issue;
    logic              pop;
    logic [2:0]        occ;
    logic [2:0]        limit;
    logic [KEX_DW-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;

    kex_skid_fifo #(.W(KEX_DW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .din   (ram_res),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign accept    = (state == IDLE) && start;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Occupancy counts the read still in flight, so a slot is always reserved for it.
    assign occ   = {1'b0, fifo_count} + {2'b00, inflight};
    assign limit = 3'd2 + {2'b00, pop};
    assign issue = (state == RUN) && (issue_cnt != n_q) &&
                   !(fifo_full && !pop) && (occ < limit);

    assign ram_addr = issue ? (base_q + issue_cnt[KEX_AW-1:0]) : '0;
    assign out_wg   = head[KEX_DW-1:KEX_IW];
    assign out_idx  = head[KEX_IW-1:0];
    assign out_last = out_valid && (pop_cnt == (n_q - KEX_CW'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            base_q    <= '0;
            n_q       <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= next_state;
            inflight <= issue;
            if (accept) begin
                base_q    <= base_addr;
                n_q       <= n_elem;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + KEX_CW'(1);
                end
                if (pop) begin
                    pop_cnt <= pop_cnt + KEX_CW'(1);
                end
            end
        end
    end

    // DRAIN counts this cycle's pop so done lands right after the final handshake.
    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = (state == FIN);
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (n_elem != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (issue_cnt == n_q) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef KEX_READER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kex_reader.sv
// Directed bench for kex_reader with a 1-cycle-latency RAM model holding RAM[i] = i.
// Checks stall_cnt as well when KEX_READER_PERF_EN is defined.
module tb_kex_reader;
    import kex_reader_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic [KEX_AW-1:0] base_addr;
    logic [KEX_CW-1:0] n_elem;
    logic              busy;
    logic              done;
    logic [KEX_AW-1:0] ram_addr;
    logic [KEX_DW-1:0] ram_res;
    logic              out_valid;
    logic              out_ready;
    logic [WG_W-1:0]   out_wg;
    logic [KEX_IW-1:0] out_idx;
    logic              out_last;
`ifdef KEX_READER_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    logic [KEX_DW-1:0] mem [KEX_N_ELEM];

    int checks;
    int failures;

    // Results captured by applyStimulus for one command
    logic [KEX_DW-1:0] beatQ[$];
    bit                lastQ[$];
    logic [KEX_AW-1:0] addrLog [1:4];
    int firstValid;
    int lastHs;
    int doneCyc;
    int doneCnt;
    int busyCycles;
    int stallCycles;
    int stableErr;
    int lastSum;

    kex_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .n_elem    (n_elem),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_res   (ram_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wg    (out_wg),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef KEX_READER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_res <= mem[ram_addr];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulses start, then samples every cycle at negedge+1 until one cycle past done.
    // readyMode 0: ready always high; 1: ready pattern 1,0,0 repeating.
    task automatic applyStimulus(input logic [KEX_AW-1:0] b, input logic [KEX_CW-1:0] n,
                                 input int readyMode, input bit injectStart);
        logic [KEX_DW:0] heldVal;
        bit held;
        beatQ.delete();
        lastQ.delete();
        for (int i = 1; i <= 4; i++) addrLog[i] = '0;
        firstValid = -1; lastHs = -1; doneCyc = -1; doneCnt = 0;
        busyCycles = 0; stallCycles = 0; stableErr = 0; lastSum = 0;
        held = 0; heldVal = '0;
        @(negedge clk);
        start = 1'b1; base_addr = b; n_elem = n; out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start     = injectStart && (cyc == 2);
            base_addr = (injectStart && cyc == 2) ? KEX_AW'(300) : b;
            n_elem    = (injectStart && cyc == 2) ? KEX_CW'(3) : n;
            out_ready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 1);
            #1;
            if (cyc <= 4) addrLog[cyc] = ram_addr;
            if (busy) busyCycles++;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                if (held && ({out_wg, out_idx, out_last} != heldVal)) stableErr++;
                if (out_ready) begin
                    beatQ.push_back({out_wg, out_idx});
                    lastQ.push_back(out_last);
                    if (out_last) lastSum++;
                    lastHs = cyc;
                    held = 0;
                end else begin
                    stallCycles++;
                    held = 1;
                    heldVal = {out_wg, out_idx, out_last};
                end
            end
            if (doneCyc >= 0 && cyc > doneCyc + 1) break;
        end
        start = 1'b0;
        if (doneCyc < 0) checkOutput("timeout_no_done", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] beatAt(input int i);
        return (i < beatQ.size()) ? 32'(beatQ[i]) : 32'hDEAD;
    endfunction

    initial begin
        checks = 0; failures = 0;
        start = 0; base_addr = '0; n_elem = '0; out_ready = 1'b1;
        for (int i = 0; i < KEX_N_ELEM; i++) mem[i] = KEX_DW'(i);
        reset = 1'b0;
        #3 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_addr", 32'(ram_addr), 0);
`ifdef KEX_READER_PERF_EN
        checkOutput("rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Test 1: base 10, n 4, full throughput
        applyStimulus(KEX_AW'(10), KEX_CW'(4), 0, 0);
        checkOutput("t1_count", beatQ.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_beat%0d", i), beatAt(i), 10 + i);
        checkOutput("t1_wg0", beatAt(0) >> KEX_IW, 1);
        checkOutput("t1_idx0", beatAt(0) & 32'h7, 2);
        checkOutput("t1_last3", (lastQ.size() == 4) ? 32'(lastQ[3]) : 0, 1);
        checkOutput("t1_last_sum", lastSum, 1);
        checkOutput("t1_first_valid", firstValid, 3);
        checkOutput("t1_last_hs", lastHs, 6);
        checkOutput("t1_done_cyc", doneCyc, 7);
        checkOutput("t1_done_cnt", doneCnt, 1);
        checkOutput("t1_busy_cycles", busyCycles, 7);

        // Test 2: address wrap at the top of the RAM
        applyStimulus(KEX_AW'(510), KEX_CW'(4), 0, 0);
        checkOutput("t2_addr1", 32'(addrLog[1]), 510);
        checkOutput("t2_addr2", 32'(addrLog[2]), 511);
        checkOutput("t2_addr3", 32'(addrLog[3]), 0);
        checkOutput("t2_addr4", 32'(addrLog[4]), 1);
        checkOutput("t2_beat0", beatAt(0), 510);
        checkOutput("t2_beat1", beatAt(1), 511);
        checkOutput("t2_beat2", beatAt(2), 0);
        checkOutput("t2_beat3", beatAt(3), 1);
        checkOutput("t2_done_cyc", doneCyc, 7);

        // Test 3: backpressure pattern 1,0,0
        applyStimulus(KEX_AW'(100), KEX_CW'(8), 1, 0);
        checkOutput("t3_count", beatQ.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("t3_beat%0d", i), beatAt(i), 100 + i);
        checkOutput("t3_last7", (lastQ.size() == 8) ? 32'(lastQ[7]) : 0, 1);
        checkOutput("t3_last_sum", lastSum, 1);
        checkOutput("t3_stable", stableErr, 0);
        checkOutput("t3_stalls", stallCycles, 15);
        checkOutput("t3_last_hs", lastHs, 25);
        checkOutput("t3_done_cyc", doneCyc, 26);
`ifdef KEX_READER_PERF_EN
        checkOutput("t3_stall_cnt", stall_cnt, 15);
`endif

        // Test 4: empty command
        applyStimulus(KEX_AW'(5), KEX_CW'(0), 0, 0);
        checkOutput("t4_first_valid", firstValid, -1);
        checkOutput("t4_count", beatQ.size(), 0);
        checkOutput("t4_done_cyc", doneCyc, 1);
        checkOutput("t4_done_cnt", doneCnt, 1);
        checkOutput("t4_busy_cycles", busyCycles, 1);
`ifdef KEX_READER_PERF_EN
        checkOutput("t4_stall_cnt_cleared", stall_cnt, 0);
`endif

        // Test 5: start while busy is ignored
        applyStimulus(KEX_AW'(40), KEX_CW'(4), 0, 1);
        checkOutput("t5_count", beatQ.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t5_beat%0d", i), beatAt(i), 40 + i);
        checkOutput("t5_done_cyc", doneCyc, 7);
        checkOutput("t5_done_cnt", doneCnt, 1);

        // Test 6: reset mid-command after three beats, then a clean n=2 run
        @(negedge clk);
        start = 1'b1; base_addr = KEX_AW'(20); n_elem = KEX_CW'(6); out_ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        #1;
        checkOutput("t6_pre_valid", 32'(out_valid), 1);
        checkOutput("t6_pre_data", 32'({out_wg, out_idx}), 23);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(out_valid), 0);
        checkOutput("t6_rst_busy", 32'(busy), 0);
        checkOutput("t6_rst_done", 32'(done), 0);
        checkOutput("t6_rst_last", 32'(out_last), 0);
        checkOutput("t6_rst_data", 32'({out_wg, out_idx}), 0);
        checkOutput("t6_rst_addr", 32'(ram_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(KEX_AW'(200), KEX_CW'(2), 0, 0);
        checkOutput("t6_count", beatQ.size(), 2);
        checkOutput("t6_beat0", beatAt(0), 200);
        checkOutput("t6_beat1", beatAt(1), 201);
        checkOutput("t6_last1", (lastQ.size() == 2) ? 32'(lastQ[1]) : 0, 1);
        checkOutput("t6_last_sum", lastSum, 1);
        checkOutput("t6_done_cyc", doneCyc, 5);
        checkOutput("t6_done_cnt", doneCnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
